// File: rtl/aes_pkg.sv
// Shared types and constants for the AES round sequencer.
package aes_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StLoad  = 3'd1,
        StRound = 3'd2,
        StFinal = 3'd3,
        StDone  = 3'd4
    } aes_ctrl_state_t;

    localparam int unsigned AES128_ROUNDS = 10;
    localparam int unsigned AES192_ROUNDS = 12;
    localparam int unsigned AES256_ROUNDS = 14;

    localparam int unsigned ROUND_IDX_W = 4;

endpackage

// File: rtl/aes_round_ctrl.sv
// Round sequencer for the AES encryption datapath: owns the FSM and round counter,
// emits one-cycle load/round/last strobes and the input/output handshakes.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int unsigned NUM_ROUNDS = AES256_ROUNDS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   rk_valid,
    output logic                   dp_capture,
    output logic                   dp_load,
    output logic                   dp_round,
    output logic                   dp_last,
    output logic [ROUND_IDX_W-1:0] round_idx,
    output logic                   busy,
    output logic                   out_valid,
    input  logic                   out_ready
);

    if (NUM_ROUNDS != AES128_ROUNDS && NUM_ROUNDS != AES192_ROUNDS &&
        NUM_ROUNDS != AES256_ROUNDS) begin : gen_bad_rounds
        $error("aes_round_ctrl: NUM_ROUNDS must be 10, 12 or 14");
    end

    localparam logic [ROUND_IDX_W-1:0] LastIdx = ROUND_IDX_W'(NUM_ROUNDS);

    aes_ctrl_state_t        state_q, state_d;
    logic [ROUND_IDX_W-1:0] idx_q, idx_d;
    logic [ROUND_IDX_W-1:0] idx_inc;
    logic                   step;

    assign step    = en & rk_valid;
    assign idx_inc = idx_q + 1'b1;

    // in_ready is gated by rst so nothing is accepted while reset is held.
    assign in_ready   = ~rst & en &
                        ((state_q == StIdle) | ((state_q == StDone) & out_ready));
    assign dp_capture = in_valid & in_ready;

    assign dp_load   = (state_q == StLoad)  & step;
    assign dp_round  = (state_q == StRound) & step;
    assign dp_last   = (state_q == StFinal) & step;
    assign busy      = (state_q == StLoad) | (state_q == StRound) | (state_q == StFinal);
    assign out_valid = (state_q == StDone);
    assign round_idx = idx_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            StIdle: begin
                if (dp_capture) begin
                    state_d = StLoad;
                    idx_d   = '0;
                end
            end
            StLoad: begin
                if (step) begin
                    state_d = StRound;
                    idx_d   = ROUND_IDX_W'(1);
                end
            end
            StRound: begin
                if (step) begin
                    idx_d = idx_inc;
                    if (idx_inc == LastIdx) begin
                        state_d = StFinal;
                    end
                end
            end
            StFinal: begin
                if (step) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    // A coincident input handshake skips IDLE entirely.
                    state_d = dp_capture ? StLoad : StIdle;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = StIdle;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl (AES-256 and AES-128 instances, shared inputs).
module tb_aes_round_ctrl;

    logic clk = 1'b0;
    logic rst, en, in_valid, rk_valid, out_ready;

    logic       ir14, cap14, ld14, rd14, ls14, busy14, ov14;
    logic [3:0] idx14;
    logic       ir10, cap10, ld10, rd10, ls10, busy10, ov10;
    logic [3:0] idx10;

    logic       sel10;
    logic       o_ir, o_cap, o_busy, o_ov;
    logic [2:0] o_str;
    logic [3:0] o_idx;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    aes_round_ctrl #(.NUM_ROUNDS(14)) dut (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(ir14),
        .rk_valid(rk_valid), .dp_capture(cap14), .dp_load(ld14), .dp_round(rd14),
        .dp_last(ls14), .round_idx(idx14), .busy(busy14), .out_valid(ov14),
        .out_ready(out_ready)
    );

    aes_round_ctrl #(.NUM_ROUNDS(10)) dut10 (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(ir10),
        .rk_valid(rk_valid), .dp_capture(cap10), .dp_load(ld10), .dp_round(rd10),
        .dp_last(ls10), .round_idx(idx10), .busy(busy10), .out_valid(ov10),
        .out_ready(out_ready)
    );

    assign o_ir   = sel10 ? ir10   : ir14;
    assign o_cap  = sel10 ? cap10  : cap14;
    assign o_busy = sel10 ? busy10 : busy14;
    assign o_ov   = sel10 ? ov10   : ov14;
    assign o_idx  = sel10 ? idx10  : idx14;
    assign o_str  = sel10 ? {ld10, rd10, ls10} : {ld14, rd14, ls14};

    // Reference model: k counts advancing cycles since the input handshake.
    // k=0 load, 1..nr-1 middle rounds, nr final round, nr+1 result valid; round_idx = k.
    task automatic run_block(input string tag, input int nr, input bit accepted,
                             input bit rand_stall, input int stall_at, input int hold,
                             input bit b2b);
        int k, cyc, stalls, stall_run;
        bit step, done;
        logic [2:0] exp_str;
        if (!accepted) begin
            in_valid = 1'b1; out_ready = 1'b0; en = 1'b1; rk_valid = 1'b1;
            #1;
            checks++;
            if ({o_ir, o_cap} !== 2'b11) begin
                errors++;
                $display("FAIL %s accept: ready/capture=%b want 11", tag, {o_ir, o_cap});
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
        k = 0; cyc = 0; stalls = 0; stall_run = 0; done = 1'b0;
        while (!done) begin
            cyc++;
            en = 1'b1; rk_valid = 1'b1;
            if (stall_at >= 0 && k == stall_at && stall_run < 3) begin
                rk_valid = 1'b0;
                stall_run++;
            end else if (rand_stall && $urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 1) == 1) en = 1'b0;
                else rk_valid = 1'b0;
            end
            step = en && rk_valid;
            #1;
            if (k <= nr) begin
                exp_str = !step ? 3'b000 : (k == 0) ? 3'b100 : (k < nr) ? 3'b010 : 3'b001;
                checks += 4;
                if (o_str !== exp_str) begin
                    errors++;
                    $display("FAIL %s strobes cyc %0d: got %b want %b", tag, cyc, o_str, exp_str);
                end
                if (o_idx !== 4'(k)) begin
                    errors++;
                    $display("FAIL %s round_idx cyc %0d: got %0d want %0d", tag, cyc, o_idx, k);
                end
                if ({o_busy, o_ov} !== 2'b10) begin
                    errors++;
                    $display("FAIL %s busy/out_valid cyc %0d: got %b want 10", tag, cyc,
                             {o_busy, o_ov});
                end
                if (o_ir !== 1'b0) begin
                    errors++;
                    $display("FAIL %s in_ready busy cyc %0d: got %b want 0", tag, cyc, o_ir);
                end
                if (step) k++;
                else stalls++;
                @(posedge clk); #1;
            end else begin
                checks += 3;
                if ({o_busy, o_ov, o_str} !== 5'b01000) begin
                    errors++;
                    $display("FAIL %s done flags: got %b want 01000", tag, {o_busy, o_ov, o_str});
                end
                if (o_idx !== 4'(nr)) begin
                    errors++;
                    $display("FAIL %s done round_idx: got %0d want %0d", tag, o_idx, nr);
                end
                if (cyc != nr + 2 + stalls) begin
                    errors++;
                    $display("FAIL %s latency: got %0d want %0d", tag, cyc, nr + 2 + stalls);
                end
                done = 1'b1;
            end
            if (!done && cyc > nr + 80) begin
                checks++; errors++;
                $display("FAIL %s timeout: no out_valid after %0d cycles", tag, cyc);
                done = 1'b1;
            end
        end
        // DONE: hold the consumer off, then release (optionally with a new block).
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            out_ready = 1'b0; in_valid = 1'b1; en = 1'b1;
            #1;
            checks++;
            if ({o_ov, o_ir, o_cap} !== 3'b100) begin
                errors++;
                $display("FAIL %s hold %0d: valid/ready/capture=%b want 100", tag, i,
                         {o_ov, o_ir, o_cap});
            end
        end
        @(posedge clk); #1;
        out_ready = 1'b1; in_valid = b2b; en = 1'b1;
        #1;
        checks++;
        if ({o_ov, o_ir, o_cap} !== {2'b11, b2b}) begin
            errors++;
            $display("FAIL %s release: valid/ready/capture=%b want %b", tag,
                     {o_ov, o_ir, o_cap}, {2'b11, b2b});
        end
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b0;
        if (!b2b) begin
            #1;
            checks++;
            if ({o_busy, o_ov, o_ir, o_idx} !== 7'b0010000) begin
                errors++;
                $display("FAIL %s back to idle: busy/valid/ready/idx=%b want 0010000", tag,
                         {o_busy, o_ov, o_ir, o_idx});
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; in_valid = 1'b1; rk_valid = 1'b1; out_ready = 1'b1;
        #1;
        checks++;
        if ({o_ir, o_cap, o_str, o_busy, o_ov, o_idx} !== 11'd0) begin
            errors++;
            $display("FAIL reset outputs: got %b want all zero",
                     {o_ir, o_cap, o_str, o_busy, o_ov, o_idx});
        end
        in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checks++;
        if (o_ir !== 1'b1) begin
            errors++;
            $display("FAIL reset release in_ready: got %b want 1", o_ir);
        end
        en = 1'b0;
        #1;
        checks++;
        if (o_ir !== 1'b0) begin
            errors++;
            $display("FAIL in_ready en low: got %b want 0", o_ir);
        end
        en = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        run_block("single", 14, 1'b0, 1'b0, -1, 0, 1'b0);
    endtask

    task automatic test_stall();
        run_block("stall", 14, 1'b0, 1'b0, 5, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_block("hold", 14, 1'b0, 1'b0, -1, 4, 1'b1);
        run_block("b2b", 14, 1'b1, 1'b0, -1, 0, 1'b0);
    endtask

    task automatic test_random();
        bit chained = 1'b0;
        bit nb;
        for (int i = 0; i < 5; i++) begin
            nb = (i < 4) && ($urandom_range(0, 1) == 1);
            run_block("random", 14, chained, 1'b1, -1, int'($urandom_range(0, 3)), nb);
            chained = nb;
        end
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1; en = 1'b1; rk_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
        end
        checks++;
        if ({o_busy, o_idx} !== 5'b10111) begin
            errors++;
            $display("FAIL mid reset setup: busy/idx=%b want 10111", {o_busy, o_idx});
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({o_ir, o_cap, o_str, o_busy, o_ov, o_idx} !== 11'd0) begin
            errors++;
            $display("FAIL mid reset outputs: got %b want all zero",
                     {o_ir, o_cap, o_str, o_busy, o_ov, o_idx});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_block("after_reset", 14, 1'b0, 1'b0, -1, 0, 1'b0);
    endtask

    task automatic test_rounds10();
        pulse_reset();
        sel10 = 1'b1;
        run_block("aes128", 10, 1'b0, 1'b0, -1, 0, 1'b0);
        run_block("aes128_rand", 10, 1'b0, 1'b1, -1, 1, 1'b0);
        sel10 = 1'b0;
        pulse_reset();
    endtask

    initial begin
        sel10 = 1'b0;
        test_reset();
        test_single();
        test_stall();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_rounds10();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_round_ctrl.md
# aes_round_ctrl

Sequencer for the AES encryption round datapath. It accepts one 128-bit block per valid/ready handshake, drives the initial AddRoundKey, the middle rounds and the final round (no MixColumns) as one-cycle strobes, and presents a valid/ready result handshake. It owns the round counter and the FSM only; state-matrix storage, S-box, ShiftRows, MixColumns and key expansion sit in the datapath and key-schedule blocks it strobes.

## Interface
- `NUM_ROUNDS`, default 14: number of rounds; legal values 10, 12, 14 (AES-128/192/256).
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `en`  in  1  global enable; low freezes sequencing and input accept.
- `in_valid`  in  1  a plaintext block and key are presented.
- `in_ready`  out  1  the controller accepts a block this cycle.
- `rk_valid`  in  1  the key schedule has the round key for `round_idx` ready.
- `dp_capture`  out  1  the datapath registers `word` and `key`; equals the input handshake.
- `dp_load`  out  1  datapath performs state = word ^ round key 0.
- `dp_round`  out  1  datapath performs a full round with round key `round_idx`.
- `dp_last`  out  1  datapath performs the final round (no MixColumns) with round key `round_idx`.
- `round_idx`  out  4  current round-key index, 0..`NUM_ROUNDS`.
- `busy`  out  1  a block is in flight (state LOAD, ROUND or FINAL).
- `out_valid`  out  1  datapath `cipher` is valid.
- `out_ready`  in  1  the consumer takes `cipher`.

## Operation
- FSM states: IDLE, LOAD, ROUND, FINAL, DONE. `step = en & rk_valid`.
- IDLE: `in_ready = en`. On `in_valid & in_ready`, assert `dp_capture`, set `round_idx` to 0 and go to LOAD.
- LOAD: `dp_load = step`. On step, set `round_idx` to 1 and go to ROUND.
- ROUND: `dp_round = step`. On step, increment `round_idx`. If the new value equals `NUM_ROUNDS`, go to FINAL.
- FINAL: `dp_last = step`. On step, go to DONE. `round_idx` holds at `NUM_ROUNDS`.
- DONE: `out_valid = 1`, independent of `en`. On `out_ready`, go to IDLE; `round_idx` becomes 0.
- Back-to-back: in DONE, `in_ready = en & out_ready`. A simultaneous output and input handshake goes directly to LOAD with `round_idx` = 0. No bubble.
- Strobes are mutually exclusive and asserted only on advancing cycles. At most one of `dp_load`, `dp_round`, `dp_last` is high in any cycle.
- `en` low, or `rk_valid` low, in LOAD/ROUND/FINAL: the state and `round_idx` hold and all strobes are 0. Sequencing resumes exactly where it stopped.
- `in_valid` while busy: ignored, because `in_ready` is 0. The input must stay stable until accepted.
- `round_idx` arithmetic: 4-bit unsigned; it never exceeds `NUM_ROUNDS`, so it cannot wrap.

## Timing
- Reset, asserted at any time including mid-block: the state goes to IDLE asynchronously and the in-flight block is discarded.
  - `round_idx` = 0.
  - `busy`, `out_valid`, `dp_capture`, `dp_load`, `dp_round`, `dp_last` = 0.
  - `in_ready` = 0 while `rst` is high, then follows `en`.
- Latency, with `en` and `rk_valid` continuously high and the input handshake in cycle T:
  - LOAD in T+1.
  - ROUND with `round_idx` 1..`NUM_ROUNDS`-1 in T+2..T+`NUM_ROUNDS`.
  - FINAL in T+`NUM_ROUNDS`+1.
  - `out_valid` from T+`NUM_ROUNDS`+2; this is T+16 for AES-256.
- Each cycle with a stall (`step` = 0) adds exactly one cycle of latency.
- Throughput with `out_ready` tied high: one block per `NUM_ROUNDS`+2 cycles.
- `in_ready` and `dp_capture` are combinational from state, `en` and `out_ready`. All other outputs are registered state decodes or combinational from state and `step`.

## Structure
- Shared package `aes_pkg`:
  - `aes_ctrl_state_t` enum.
  - Constants `AES128_ROUNDS` = 10, `AES192_ROUNDS` = 12, `AES256_ROUNDS` = 14.
  - `ROUND_IDX_W` = 4.
- Single module; no sub-module is needed. An elaboration-time check rejects any `NUM_ROUNDS` value other than 10, 12 or 14.

## Test plan
- Reset, then one block with `en`, `rk_valid` and `out_ready` high, handshake at cycle T:
  - `dp_load` in T+1.
  - 13 `dp_round` pulses with `round_idx` 1..13.
  - `dp_last` in T+15 with `round_idx` 14.
  - `out_valid` in T+16.
- Drop `rk_valid` for 3 cycles during round 5: `round_idx` holds at 5 with no strobes; `out_valid` arrives at T+19.
- Hold `out_ready` low for 4 cycles in DONE: `out_valid` stays high and `in_ready` stays 0. Then pulse `out_ready` together with `in_valid`: `dp_load` is asserted in the next cycle.
- Assert `rst` mid-ROUND with `round_idx` = 7: all outputs go to their reset values immediately. After release, a new block completes with normal latency.
- Set `NUM_ROUNDS` = 10: exactly 9 `dp_round` pulses, `dp_last` with `round_idx` = 10, and `out_valid` at T+12.
